// File: rtl/energy_store.sv
// energy_store: saturating energy level with band classification and a
// tick-driven AWAKE/DROWSY/ASLEEP sleep FSM.
`default_nettype none

module energy_store #(
    parameter int WIDTH        = 8,
    parameter int PRESCALE     = 4,
    parameter int STEP         = 1,
    parameter int INIT         = 128,
    parameter int THR_TIRED    = 64,
    parameter int THR_RESTED   = 192,
    parameter int DROWSY_TICKS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             energy_inc,
    input  logic             energy_dec,
    output logic [WIDTH-1:0] energy_level,
    output logic [1:0]       energy_class,
    output logic             drowsy,
    output logic             sleep_req,
    output logic             wake_pulse
);

    localparam int c_pw = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_cw = $clog2(DROWSY_TICKS + 1);

    localparam logic [c_pw-1:0]  c_pre_last   = c_pw'(PRESCALE - 1);
    localparam logic [WIDTH:0]   c_step       = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] c_init       = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] c_max        = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_thr_tired  = WIDTH'(THR_TIRED);
    localparam logic [WIDTH-1:0] c_thr_rested = WIDTH'(THR_RESTED);
    localparam logic [c_cw-1:0]  c_drowsy_max = c_cw'(DROWSY_TICKS);

    localparam logic [1:0] c_st_awake  = 2'd0;
    localparam logic [1:0] c_st_drowsy = 2'd1;
    localparam logic [1:0] c_st_asleep = 2'd2;

    logic [c_pw-1:0]  r_pre;
    logic             w_tick;
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] w_level_nxt;
    logic [WIDTH:0]   w_up;
    logic [WIDTH:0]   w_dn;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [c_cw-1:0]  r_cnt;
    logic [c_cw-1:0]  w_cnt_nxt;
    logic             r_wake;
    logic             w_wake_nxt;
    logic             w_low;
    logic             w_rested;

    // Prescaler: tick marks the last cycle of each PRESCALE-cycle window.
    assign w_tick = (r_pre == c_pre_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // One extra bit exposes overflow (up) and borrow (down) for saturation.
    assign w_up = {1'b0, r_level} + c_step;
    assign w_dn = {1'b0, r_level} - c_step;

    always_comb begin
        w_level_nxt = r_level;
        if (w_tick && energy_inc && !energy_dec) begin
            w_level_nxt = w_up[WIDTH] ? c_max : w_up[WIDTH-1:0];
        end else if (w_tick && energy_dec && !energy_inc) begin
            w_level_nxt = w_dn[WIDTH] ? '0 : w_dn[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= c_init;
        end else begin
            r_level <= w_level_nxt;
        end
    end

    assign energy_level = r_level;

    always_comb begin
        if (r_level == c_max) begin
            energy_class = 2'b11;
        end else if (r_level >= c_thr_rested) begin
            energy_class = 2'b10;
        end else if (r_level >= c_thr_tired) begin
            energy_class = 2'b01;
        end else begin
            energy_class = 2'b00;
        end
    end

    // FSM decisions use the pre-update level so both actions share one tick.
    assign w_low    = (r_level < c_thr_tired);
    assign w_rested = (r_level >= c_thr_rested);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_awake;
            r_cnt   <= '0;
            r_wake  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wake  <= w_wake_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wake_nxt  = 1'b0;
        case (r_state)
            c_st_awake: begin
                if (w_tick && w_low) begin
                    w_state_nxt = c_st_drowsy;
                    w_cnt_nxt   = c_cw'(1);
                end
            end
            c_st_drowsy: begin
                if (w_tick) begin
                    if (!w_low) begin
                        w_state_nxt = c_st_awake;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_drowsy_max) begin
                        w_state_nxt = c_st_asleep;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            c_st_asleep: begin
                if (w_tick && w_rested) begin
                    w_state_nxt = c_st_awake;
                    w_wake_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_awake;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        drowsy     = (r_state == c_st_drowsy);
        sleep_req  = (r_state == c_st_asleep);
        wake_pulse = r_wake;
    end

endmodule

`default_nettype wire

// File: tb/tb_energy_store.sv
// tb_energy_store: directed and randomized checks of two energy_store
// instances (PRESCALE=4/INIT=128 and PRESCALE=1/INIT=64) against a behavioural model.
`default_nettype none

module tb_energy_store;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inc_s = 1'b0, dec_s = 1'b0, inc_f = 1'b0, dec_f = 1'b0;
    logic [7:0] lvl_s, lvl_f;
    logic [1:0] cls_s, cls_f;
    logic       dr_s, dr_f, sr_s, sr_f, wp_s, wp_f;

    int checks = 0;
    int errors = 0;

    // Model state per instance: 0 = slow (PRESCALE 4), 1 = fast (PRESCALE 1)
    int c_p[2]    = '{4, 1};
    int c_init[2] = '{128, 64};
    int m_level[2];
    int m_pre[2];
    int m_low[2];     // consecutive low ticks seen while not asleep
    bit m_asleep[2];
    bit m_wake[2];

    always #5 clk = ~clk;

    energy_store #(.PRESCALE(4), .INIT(128)) u_slow (
        .clk(clk), .rst(rst), .energy_inc(inc_s), .energy_dec(dec_s),
        .energy_level(lvl_s), .energy_class(cls_s),
        .drowsy(dr_s), .sleep_req(sr_s), .wake_pulse(wp_s)
    );

    energy_store #(.PRESCALE(1), .INIT(64)) u_fast (
        .clk(clk), .rst(rst), .energy_inc(inc_f), .energy_dec(dec_f),
        .energy_level(lvl_f), .energy_class(cls_f),
        .drowsy(dr_f), .sleep_req(sr_f), .wake_pulse(wp_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp))
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int band(input int l);
        if (l == 255) return 3;
        if (l >= 192) return 2;
        if (l >= 64)  return 1;
        return 0;
    endfunction

    task automatic model(input int i, input bit r, input bit inc, input bit dec);
        bit tick;
        int pre_l;
        if (r) begin
            m_level[i] = c_init[i];
            m_pre[i] = 0; m_low[i] = 0; m_asleep[i] = 0; m_wake[i] = 0;
        end else begin
            tick = (m_pre[i] == c_p[i] - 1);
            m_pre[i] = tick ? 0 : m_pre[i] + 1;
            m_wake[i] = 0;
            if (tick) begin
                pre_l = m_level[i];
                if (inc && !dec)      m_level[i] = (pre_l + 1 > 255) ? 255 : pre_l + 1;
                else if (dec && !inc) m_level[i] = (pre_l - 1 < 0) ? 0 : pre_l - 1;
                if (m_asleep[i]) begin
                    if (pre_l >= 192) begin
                        m_asleep[i] = 0;
                        m_wake[i] = 1;
                    end
                end else if (pre_l < 64) begin
                    m_low[i]++;
                    if (m_low[i] > 8) begin
                        m_asleep[i] = 1;
                        m_low[i] = 0;
                    end
                end else begin
                    m_low[i] = 0;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit is, input bit ds, input bit if_, input bit df);
        rst = r; inc_s = is; dec_s = ds; inc_f = if_; dec_f = df;
        @(posedge clk);
        model(0, r, is, ds);
        model(1, r, if_, df);
        #1;
        chk("slow_level",  lvl_s, m_level[0]);
        chk("slow_class",  cls_s, band(m_level[0]));
        chk("slow_drowsy", dr_s,  int'(!m_asleep[0] && m_low[0] > 0));
        chk("slow_sleep",  sr_s,  int'(m_asleep[0]));
        chk("slow_wake",   wp_s,  int'(m_wake[0]));
        chk("fast_level",  lvl_f, m_level[1]);
        chk("fast_class",  cls_f, band(m_level[1]));
        chk("fast_drowsy", dr_f,  int'(!m_asleep[1] && m_low[1] > 0));
        chk("fast_sleep",  sr_f,  int'(m_asleep[1]));
        chk("fast_wake",   wp_f,  int'(m_wake[1]));
    endtask

    initial begin
        int mode;
        bit r, a, b, c, d;

        // Reset and idle
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 40; k++) step(0, 0, 0, 0, 0);
        chk("idle_level", lvl_s, 128);
        chk("idle_class", cls_s, 1);

        // Prescale timing on the slow instance
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0);
        chk("pre_hold", lvl_s, 128);
        step(0, 1, 0, 0, 0);
        chk("pre_first", lvl_s, 129);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0);
        chk("pre_second", lvl_s, 130);

        // Sleep entry on the fast instance
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("dec_63", lvl_f, 63);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 0);
        chk("still_drowsy", dr_f, 1);
        chk("not_asleep_yet", sr_f, 0);
        step(0, 0, 0, 0, 0);
        chk("asleep", sr_f, 1);

        // Wake with hysteresis, then saturate high
        for (int k = 0; k < 200; k++) step(0, 0, 0, 1, 0);
        chk("sat_high", lvl_f, 255);
        chk("sat_high_class", cls_f, 3);
        chk("awake_after_rise", sr_f, 0);

        // Saturate low, then inc and dec together hold
        for (int k = 0; k < 300; k++) step(0, 0, 0, 0, 1);
        chk("sat_low", lvl_f, 0);
        chk("sat_low_class", cls_f, 0);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 1, 1);
        chk("both_hold", lvl_f, 0);

        // Drowsy cancel
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int k = 0; k < 12; k++) step(0, 0, 0, 0, 0);
        chk("cancel_level", lvl_f, 64);
        chk("cancel_sleep", sr_f, 0);
        chk("cancel_drowsy", dr_f, 0);

        // Reset while asleep at level 100
        step(0, 0, 0, 0, 1);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0);
        for (int k = 0; k < 37; k++) step(0, 0, 0, 1, 0);
        chk("mid_level", lvl_f, 100);
        chk("mid_sleep", sr_f, 1);
        step(1, 0, 0, 0, 0);
        chk("rst_level", lvl_f, 64);
        chk("rst_sleep", sr_f, 0);

        // Randomized segments biased towards rising, falling or mixed levels
        for (int seg = 0; seg < 20; seg++) begin
            mode = $urandom_range(0, 2);
            for (int k = 0; k < 150; k++) begin
                r = ($urandom_range(0, 599) == 0);
                a = (mode == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                b = (mode == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                c = (mode == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                d = (mode == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                if (mode == 2) begin
                    a = $urandom_range(0, 1); b = $urandom_range(0, 1);
                    c = $urandom_range(0, 1); d = $urandom_range(0, 1);
                end
                step(r, a, b, c, d);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/energy_store.md
Name: energy_store

Overview:
- Integrating end of the energy path: consumes the energy_inc / energy_dec level requests from the energy regulator.
- Holds a saturating energy level and classifies it into four bands.
- Runs a sleep FSM whose sleep_req / drowsy / wake_pulse outputs feed back to the sleep controller.
- Sits between the energy regulator and the sleep controller in the mimosa mood core.

Parameters:
- WIDTH, 8, bit width of the energy level.
- PRESCALE, 4, clk cycles per update tick (>=1).
- STEP, 1, level change per tick.
- INIT, 128, level after reset.
- THR_TIRED, 64, level below this is "exhausted".
- THR_RESTED, 192, level at or above this is "energetic"; must be > THR_TIRED.
- DROWSY_TICKS, 8, consecutive low ticks in DROWSY before ASLEEP (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- energy_inc  input  1  level request: raise energy.
- energy_dec  input  1  level request: lower energy.
- energy_level  output  WIDTH  registered energy level.
- energy_class  output  2  00 exhausted, 01 normal, 10 energetic, 11 full.
- drowsy  output  1  high while FSM is in DROWSY.
- sleep_req  output  1  high while FSM is in ASLEEP.
- wake_pulse  output  1  one-cycle pulse on the ASLEEP->AWAKE transition.

Behaviour:
- Reset (synchronous, active-high, single clock):
  - prescaler=0, level=INIT, FSM=AWAKE, drowsy count=0.
  - Outputs: energy_level=INIT, energy_class per INIT (01 at defaults), drowsy=0, sleep_req=0, wake_pulse=0.
  - Reset asserted mid-operation overrides everything on that edge and restores these values.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps; tick=1 in the cycle where count==PRESCALE-1.
  - First tick is the PRESCALE-th cycle after rst deasserts. PRESCALE=1 gives a tick every cycle.
- Level update (only on a tick cycle; inputs ignored otherwise):
  - inc=1, dec=0: level <= min(level+STEP, 2^WIDTH-1).
  - dec=1, inc=0: level <= max(level-STEP, 0).
  - Both or neither: hold.
  - Arithmetic is done in WIDTH+1 bits to saturate; no wrap-around at either end.
  - New value is visible on energy_level the cycle after the tick.
- energy_class (combinational from the registered level):
  - 11 if level == 2^WIDTH-1.
  - else 10 if level >= THR_RESTED.
  - else 01 if level >= THR_TIRED.
  - else 00.
- FSM (transitions only on tick cycles, evaluated on the current registered level, i.e. before that tick's update):
  - AWAKE: level < THR_TIRED -> DROWSY, drowsy count=1.
  - DROWSY, level >= THR_TIRED: -> AWAKE (cancel), count=0.
  - DROWSY, level < THR_TIRED, count == DROWSY_TICKS: -> ASLEEP.
  - DROWSY, level < THR_TIRED, otherwise: count+1.
  - ASLEEP: level >= THR_RESTED -> AWAKE, wake_pulse=1 for exactly the next cycle.
  - Intermediate levels in ASLEEP keep sleeping (hysteresis).
  - drowsy, sleep_req and wake_pulse are registered decodes of the state and change the cycle after the transitioning tick.
- Simultaneous events: level update and FSM transition on the same tick are both performed; the FSM uses the pre-update level.
- No illegal-state lockup: unused state encodings go to AWAKE on the next clock.

Test Plan:
- Reset/idle: PRESCALE=4, hold rst 2 cycles, inputs 0 for 40 cycles -> energy_level=128, class=01, drowsy=sleep_req=wake_pulse=0 throughout.
- Prescale timing: PRESCALE=4, energy_inc=1 from reset release -> level 129 visible after cycle 4, 130 after cycle 8; no change on non-tick cycles.
- Saturation:
  - PRESCALE=1, INIT=250, energy_inc=1 for 10 cycles -> level stops at 255, class=11.
  - INIT=3, energy_dec=1 for 10 cycles -> level stops at 0, class=00.
  - inc=dec=1 -> level held.
- Sleep entry and cancel:
  - PRESCALE=1, INIT=64, energy_dec=1 for 1 cycle -> level 63, DROWSY next.
  - Hold inputs 0 -> sleep_req=1 after 8 ticks in DROWSY.
  - Repeat, but pulse energy_inc at the 4th DROWSY tick -> level 64, back to AWAKE, sleep_req never asserts.
- Wake with hysteresis: from ASLEEP at level 63, energy_inc=1 -> sleep_req stays 1 through levels 64..191. On the tick seen at level 192: AWAKE, wake_pulse high exactly 1 cycle, sleep_req=0.
- Reset mid-sleep: assert rst while ASLEEP at level 100 -> next cycle level=128, FSM AWAKE, all status outputs 0.
